// File: rtl/axis_to_serial_tx_pkg.sv
// Shared definitions for the serial host link: polarity, mode, synchronizer
// depth and the transmitter state encoding.
package axis_to_serial_tx_pkg;

    localparam int   SPI_MODE            = 0;
    localparam int   SYNC_STAGES_DEFAULT = 2;
    localparam logic CS_ACTIVE           = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

    // Bit counter must hold 0..data_width inclusive.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by one
// edge-detect register producing single-clk rise/fall pulses.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchronizer chain plus registered edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{RESET_VAL}};
            prev_r <= RESET_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/axis_to_serial_tx.sv
// SPI-slave (mode 0) transmitter: one-word hold buffer feeding a shift
// register that the host clocks out MSB first on serial_miso.
module axis_to_serial_tx
    import axis_to_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  serial_sck,
    input  logic                  serial_cs,
    output logic                  serial_miso,
    output logic                  serial_rts,
    output logic                  serial_eop,
    output logic                  underrun
);

    localparam int             CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (serial_sck),
        .rise     (sck_rise_s),
        .fall     (sck_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(~CS_ACTIVE)) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (serial_cs),
        .rise     (cs_rise_s),
        .fall     (cs_fall_s)
    );

    tx_state_e             state_r;
    logic [DATA_WIDTH-1:0] hold_data_r;
    logic                  hold_last_r;
    logic                  hold_valid_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shadow_r;
    logic                  shift_active_r;
    logic                  eop_r;
    logic [CNT_W-1:0]      bitcnt_r;
    logic                  tready_r;
    logic                  miso_r;
    logic                  rts_r;
    logic                  underrun_r;

    logic accept_s, sck_rise_q_s, sck_fall_q_s, full_s;
    logic retire_s, abort_s, transfer_s;
    logic hold_valid_nxt_s, shift_active_nxt_s;

    // Qualify host clock edges and decide retire/abort/transfer for this cycle.
    always_comb begin
        accept_s           = s_axis_tvalid & tready_r;
        sck_rise_q_s       = sck_rise_s & (state_r != ST_IDLE);
        sck_fall_q_s       = sck_fall_s & (state_r == ST_SHIFT);
        full_s             = (bitcnt_r == CNT_FULL);
        retire_s           = shift_active_r & full_s & (sck_fall_q_s | cs_rise_s);
        abort_s            = shift_active_r & cs_rise_s & ~full_s & (bitcnt_r != CNT_ZERO);
        transfer_s         = hold_valid_r & (~shift_active_r | retire_s);
        hold_valid_nxt_s   = accept_s | (hold_valid_r & ~transfer_s);
        shift_active_nxt_s = transfer_s | (shift_active_r & ~retire_s);
    end

    // Transaction FSM, AXIS hold buffer and shift datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            hold_data_r    <= '0;
            hold_last_r    <= 1'b0;
            hold_valid_r   <= 1'b0;
            shift_r        <= '0;
            shadow_r       <= '0;
            shift_active_r <= 1'b0;
            eop_r          <= 1'b0;
            bitcnt_r       <= CNT_ZERO;
            tready_r       <= 1'b0;
            miso_r         <= 1'b0;
            rts_r          <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) state_r <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (cs_rise_s)         state_r <= ST_IDLE;
                    else if (sck_rise_q_s) state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_rise_s) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase

            if (accept_s) begin
                hold_data_r <= s_axis_tdata;
                hold_last_r <= s_axis_tlast;
            end
            hold_valid_r   <= hold_valid_nxt_s;
            tready_r       <= ~hold_valid_nxt_s;
            shift_active_r <= shift_active_nxt_s;
            rts_r          <= hold_valid_nxt_s | shift_active_nxt_s;
            underrun_r     <= sck_rise_q_s & ~shift_active_r;

            // A cs rise mid-word restores the shadow so the host can resend it.
            if (transfer_s) begin
                shift_r  <= hold_data_r;
                shadow_r <= hold_data_r;
                eop_r    <= hold_last_r;
                bitcnt_r <= CNT_ZERO;
                miso_r   <= hold_data_r[DATA_WIDTH-1];
            end else if (retire_s) begin
                eop_r    <= 1'b0;
                bitcnt_r <= CNT_ZERO;
                miso_r   <= 1'b0;
            end else if (abort_s) begin
                shift_r  <= shadow_r;
                bitcnt_r <= CNT_ZERO;
                miso_r   <= shadow_r[DATA_WIDTH-1];
            end else if (shift_active_r && sck_rise_q_s && !full_s) begin
                bitcnt_r <= bitcnt_r + CNT_ONE;
            end else if (shift_active_r && sck_fall_q_s && !full_s) begin
                shift_r  <= {shift_r[DATA_WIDTH-2:0], 1'b0};
                miso_r   <= shift_r[DATA_WIDTH-2];
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign serial_miso   = miso_r;
    assign serial_rts    = rts_r;
    assign serial_eop    = eop_r;
    assign underrun      = underrun_r;

endmodule

// File: tb/tb_axis_to_serial_tx.sv
// Scoreboard bench: words are queued on AXIS accept and compared against the
// bits a modelled SPI host clocks out at clk/8.
module tb_axis_to_serial_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = 32'h0;
    logic        serial_sck = 1'b0;
    logic        serial_cs = 1'b1;
    logic        serial_miso;
    logic        serial_rts;
    logic        serial_eop;
    logic        underrun;

    int          total = 0;
    int          bad = 0;
    int          ucnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    axis_to_serial_tx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .serial_sck    (serial_sck),
        .serial_cs     (serial_cs),
        .serial_miso   (serial_miso),
        .serial_rts    (serial_rts),
        .serial_eop    (serial_eop),
        .underrun      (underrun)
    );

    always @(negedge clk) if (underrun === 1'b1) ucnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic axis_send(input logic [31:0] d, input logic l, input logic keep_valid);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL axis_accept_timeout: tready=%b required=1", s_axis_tready);
        end
        @(negedge clk);
        exp_q.push_back(d);
        if (!keep_valid) s_axis_tvalid = 1'b0;
    endtask

    task automatic sck_cycle(output logic b, output logic e, output logic r);
        b = serial_miso;
        e = serial_eop;
        r = serial_rts;
        serial_sck = 1'b1;
        repeat (4) @(negedge clk);
        serial_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_begin();
        serial_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        serial_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic read_word(input logic exp_eop, input string tag);
        logic [31:0] w;
        logic [31:0] exp;
        logic        b, e, r;
        w = 32'h0;
        for (int i = 0; i < 32; i++) begin
            sck_cycle(b, e, r);
            w = {w[30:0], b};
            total++;
            if (e !== exp_eop || r !== 1'b1) begin
                bad++;
                $display("FAIL %s_flags bit%0d: eop=%b rts=%b required eop=%b rts=1", tag, i, e, r, exp_eop);
            end
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_word: got %h but scoreboard empty", tag, w);
        end else begin
            exp = exp_q.pop_front();
            if (w !== exp) begin
                bad++;
                $display("FAIL %s_word: got %h required %h", tag, w, exp);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({serial_miso, serial_rts, serial_eop, underrun, s_axis_tready} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs: miso,rts,eop,underrun,tready=%b required 00000",
                     {serial_miso, serial_rts, serial_eop, underrun, s_axis_tready});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_tready: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_single_word();
        int u0;
        u0 = ucnt;
        axis_send(32'hA5C3_0F01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if ({serial_rts, serial_miso, serial_eop} !== 3'b111) begin
            bad++;
            $display("FAIL single_preload: rts,miso,eop=%b required 111", {serial_rts, serial_miso, serial_eop});
        end
        cs_begin();
        read_word(1'b1, "single");
        total++;
        if (serial_rts !== 1'b0 || serial_eop !== 1'b0) begin
            bad++;
            $display("FAIL single_rts_fall: rts=%b eop=%b required 0 0", serial_rts, serial_eop);
        end
        total++;
        if (ucnt != u0) begin
            bad++;
            $display("FAIL single_underrun: pulses=%0d required 0", ucnt - u0);
        end
        cs_end();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                axis_send(32'h1111_1111, 1'b0, 1'b1);
                axis_send(32'h2222_2222, 1'b0, 1'b1);
                axis_send(32'h3333_3333, 1'b1, 1'b0);
            end
            begin
                repeat (20) @(negedge clk);
                total++;
                if (s_axis_tready !== 1'b0 || serial_rts !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_hold_full: tready=%b rts=%b required 0 1", s_axis_tready, serial_rts);
                end
                cs_begin();
                read_word(1'b0, "b2b_w0");
                read_word(1'b0, "b2b_w1");
                read_word(1'b1, "b2b_w2");
                total++;
                if (serial_rts !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_rts_end: got %b required 0", serial_rts);
                end
                cs_end();
            end
        join
    endtask

    task automatic test_underrun();
        int   u0;
        logic b, e, r;
        u0 = ucnt;
        cs_begin();
        for (int i = 0; i < 8; i++) begin
            sck_cycle(b, e, r);
            total++;
            if (b !== 1'b0 || r !== 1'b0) begin
                bad++;
                $display("FAIL underrun_bit%0d: miso=%b rts=%b required 0 0", i, b, r);
            end
        end
        total++;
        if (ucnt - u0 != 8) begin
            bad++;
            $display("FAIL underrun_pulses: got %0d required 8", ucnt - u0);
        end
        cs_end();
    endtask

    task automatic test_abort_resend();
        logic [9:0] w10;
        logic       b, e, r;
        w10 = 10'h0;
        axis_send(32'hDEAD_BEEF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        cs_begin();
        for (int i = 0; i < 10; i++) begin
            sck_cycle(b, e, r);
            w10 = {w10[8:0], b};
        end
        total++;
        if (w10 !== 10'b1101111010) begin
            bad++;
            $display("FAIL abort_partial: got %b required 1101111010", w10);
        end
        cs_end();
        total++;
        if (serial_rts !== 1'b1 || serial_miso !== 1'b1) begin
            bad++;
            $display("FAIL abort_not_retired: rts=%b miso=%b required 1 1", serial_rts, serial_miso);
        end
        cs_begin();
        read_word(1'b0, "abort_resend");
        total++;
        if (serial_rts !== 1'b0) begin
            bad++;
            $display("FAIL abort_retired: rts=%b required 0", serial_rts);
        end
        cs_end();
    endtask

    task automatic test_reset_mid();
        logic [15:0] w16;
        logic        b, e, r;
        w16 = 16'h0;
        axis_send(32'h1234_5678, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        cs_begin();
        for (int i = 0; i < 16; i++) begin
            sck_cycle(b, e, r);
            w16 = {w16[14:0], b};
        end
        total++;
        if (w16 !== 16'h1234) begin
            bad++;
            $display("FAIL resetmid_partial: got %h required 1234", w16);
        end
        reset = 1'b1;
        serial_cs = 1'b1;
        #1;
        total++;
        if ({serial_miso, serial_rts, s_axis_tready} !== 3'b000) begin
            bad++;
            $display("FAIL resetmid_async: miso,rts,tready=%b required 000", {serial_miso, serial_rts, s_axis_tready});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL resetmid_tready: got %b required 1", s_axis_tready);
        end
        repeat (8) @(negedge clk);
        axis_send(32'h0000_FFFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        cs_begin();
        read_word(1'b1, "resetmid_next");
        cs_end();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_abort_resend();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
